mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the core's instruction-fetch port and its load/store data port.
- Serialises accesses and applies round-robin arbitration when both ports request.
- Enforces a per-access acknowledge timeout.
- Sits between the core datapath (which supplies the instruction word and load data) and the memory model/bus.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width (fixed at 32; strobe is DATA_W/8)
TIMEOUT, 255, max cycles waiting for m_ack before error completion (1..2^16-1)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request, held until if_ready
if_addr  in  ADDR_W  fetch address, stable while if_req
if_ready  out  1  one-cycle fetch completion pulse
if_rdata  out  DATA_W  instruction word, valid with if_ready
if_err  out  1  fetch timed out, valid with if_ready
d_req  in  1  data request, held until d_ready
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_wstrb  in  4  store byte enables
d_ready  out  1  one-cycle data completion pulse
d_rdata  out  DATA_W  load data, valid with d_ready (0 for stores)
d_err  out  1  data access timed out, valid with d_ready
m_req  out  1  memory request, held until m_ack or timeout
m_we  out  1  memory write enable
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_wstrb  out  4  memory byte enables (0 on reads)
m_ack  in  1  memory completion, one cycle
m_rdata  in  DATA_W  read data, valid with m_ack

Behaviour:
- Reset (async, rst_n=0): state IDLE, last_grant=IF (next tie goes to D), all outputs 0, timeout counter 0. Reset mid-access drops m_req immediately; the access is abandoned; no ready pulse is issued.
- States: IDLE, BUSY_IF, BUSY_D, RESP.
- IDLE:
  - One requester active: grant it.
  - Both active: grant the one not in last_grant.
  - On grant: capture addr/we/wdata/wstrb into registers, set last_grant, go to BUSY_x.
  - Fetch grant forces m_we=0 and m_wstrb=0.
- BUSY_x:
  - m_req=1 and m_* are driven from the captured registers, not the live inputs.
  - Counter increments each cycle.
  - m_ack=1: capture m_rdata (d_rdata forced 0 for stores), err=0, go to RESP.
  - Counter reaches TIMEOUT with no ack: rdata=0, err=1, go to RESP.
  - m_req deasserts in the cycle after ack or timeout.
- RESP: pulse the granted port's ready for exactly one cycle with registered rdata/err, then go to IDLE. Requests are not sampled in RESP.
- Latency: req sampled at edge N, m_req high from N+1. With ack at edge M, ready is high in the cycle after M. Minimum req-to-ready is 3 cycles (ack in first busy cycle).
- Requester rule: drop req in the cycle ready is high. If req is still high in IDLE after RESP, it is treated as a new request.
- The non-granted requester waits with req held; no request is lost.
- Alternation guarantee: with both requesting continuously, grants alternate IF, D, IF, D.
- m_ack outside BUSY_x is ignored and counted by nothing.
- m_ack in the same cycle the timeout is reached: ack wins, err=0.
- Counter width is clog2(TIMEOUT+1). The counter clears on every grant.
- All outputs are registered.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum localparams (IDLE=2'd0, BUSY_IF=2'd1, BUSY_D=2'd2, RESP=2'd3)
  - requester IDs (GNT_IF=1'b0, GNT_D=1'b1)
  - strobe width constant
- One natural sub-module: rr_arb2, a 2-way round-robin grant combinational unit with last_grant input. The FSM and timeout stay in mem_arbiter.

Test Plan:
- Fetch only: if_addr=0x10, memory acks 1 cycle after m_req with 0x00500093 -> m_addr=0x10, m_we=0; if_ready one cycle with if_rdata=0x00500093, if_err=0; d_ready stays 0.
- Store: d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, d_wstrb=4'hF, ack delay 3 -> m_* match the inputs throughout busy, even when inputs change after grant; d_ready=1, d_rdata=0.
- Contention: if_req and d_req both held, 4 accesses -> grant order D, IF, D, IF after reset; each port sees exactly 2 ready pulses.
- Timeout: d_req load, m_ack never asserted, TIMEOUT=8 -> m_req high for 8 cycles then low; d_ready=1, d_err=1, d_rdata=0; return to IDLE.
- Ack on timeout cycle: TIMEOUT=4, ack in 4th busy cycle with m_rdata=0x1234 -> err=0, rdata=0x1234.
- Reset mid-access: rst_n low during BUSY_IF -> m_req=0 asynchronously and no if_ready; after release, a fresh if_req completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, requester IDs and strobe width for the memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

  localparam int STRB_W = 4;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; on a tie the port that did not win last time wins
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic req_if,
  input  logic req_d,
  input  logic last_grant,
  output logic valid,
  output logic grant
);

  // a lone requester wins outright, a tie goes to the port not granted last
  always_comb begin
    valid = req_if | req_d;
    grant = (req_if & req_d) ? ~last_grant : (req_d ? GNT_D : GNT_IF);
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises fetch and load/store accesses onto one single-port memory with a per-access ack timeout
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [STRB_W-1:0] d_wstrb,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [STRB_W-1:0] m_wstrb,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state;
  logic              last_grant;
  logic              gnt_valid;
  logic              gnt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              timed_out;

  rr_arb2 u_arb (
    .req_if     (if_req),
    .req_d      (d_req),
    .last_grant (last_grant),
    .valid      (gnt_valid),
    .grant      (gnt)
  );

  // the cycle whose edge would complete the TIMEOUT-th busy cycle without an ack
  assign timed_out = cnt == CNT_W'(TIMEOUT - 1);

  // response payload is shared; each port only looks at it while its own ready is high
  assign if_rdata = rsp_data;
  assign if_err   = rsp_err;
  assign d_rdata  = rsp_data;
  assign d_err    = rsp_err;

  // access FSM: grant, hold the captured request on the bus until ack or timeout, then pulse ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= GNT_IF;
      cnt        <= '0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_wstrb    <= '0;
      if_ready   <= 1'b0;
      d_ready    <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            state      <= (gnt == GNT_D) ? BUSY_D : BUSY_IF;
            last_grant <= gnt;
            cnt        <= '0;
            m_req      <= 1'b1;
            m_addr     <= (gnt == GNT_D) ? d_addr : if_addr;
            m_we       <= (gnt == GNT_D) & d_we;
            m_wdata    <= (gnt == GNT_D) ? d_wdata : '0;
            m_wstrb    <= ((gnt == GNT_D) & d_we) ? d_wstrb : '0;
          end
        end
        BUSY_IF, BUSY_D: begin
          cnt <= cnt + 1'b1;
          if (m_ack || timed_out) begin
            state    <= RESP;
            m_req    <= 1'b0;
            rsp_err  <= ~m_ack;
            rsp_data <= (m_ack && !m_we) ? m_rdata : '0;
            if_ready <= state == BUSY_IF;
            d_ready  <= state == BUSY_D;
          end
        end
        RESP: begin
          state    <= IDLE;
          if_ready <= 1'b0;
          d_ready  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a transaction-timing reference model
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_ready, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_ready, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb, m_wstrb;
  logic        m_req, m_we, m_ack;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int vecs = 0;
  int errs = 0;
  int n = 0;

  // reference model: when the current access occupies the bus and when its response is due
  int          g_edge, len, rsp_cyc, free_edge, dly;
  logic        g_port = GNT_IF, last;
  logic [31:0] e_addr, e_wdata, e_mem, e_rsp;
  logic        e_we, e_err;
  logic [3:0]  e_wstrb;

  // requester / memory stimulus controls
  int          if_todo = 0, d_todo = 0, fix_dly = 0;
  bit          rnd = 0, scr = 0, fix_rd_en = 0;
  logic [31:0] if_nxt, d_nxt_addr, d_nxt_wdata, fix_rd;
  logic        d_nxt_we;
  logic [3:0]  d_nxt_wstrb;

  // observations
  logic        prev_mreq;
  int          if_cnt = 0, d_cnt = 0, mreq_cnt = 0;
  logic [31:0] glog[$];
  logic [31:0] order[4];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) n <= n + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    g_edge = -100; len = 0; rsp_cyc = -100; free_edge = 0;
    last = GNT_IF; prev_mreq = 1'b0;
  endtask

  // one clock of the whole environment, evaluated at the falling edge
  task automatic cycle();
    logic win, fire;
    @(negedge clk);
    win = n >= g_edge && n < g_edge + len;
    chk("m_req", {31'd0, m_req}, {31'd0, win});
    if (win) begin
      chk("m_addr", m_addr, e_addr);
      chk("m_we", {31'd0, m_we}, {31'd0, e_we});
      chk("m_wstrb", {28'd0, m_wstrb}, {28'd0, e_wstrb});
      if (e_we) chk("m_wdata", m_wdata, e_wdata);
    end
    chk("if_ready", {31'd0, if_ready}, {31'd0, n == rsp_cyc && g_port == GNT_IF});
    chk("d_ready", {31'd0, d_ready}, {31'd0, n == rsp_cyc && g_port == GNT_D});
    if (n == rsp_cyc && g_port == GNT_IF) begin
      chk("if_rdata", if_rdata, e_rsp);
      chk("if_err", {31'd0, if_err}, {31'd0, e_err});
    end
    if (n == rsp_cyc && g_port == GNT_D) begin
      chk("d_rdata", d_rdata, e_rsp);
      chk("d_err", {31'd0, d_err}, {31'd0, e_err});
    end
    if (m_req && !prev_mreq) glog.push_back(m_addr);
    prev_mreq = m_req;
    mreq_cnt += int'(m_req);
    if_cnt += int'(if_ready);
    d_cnt += int'(d_ready);
    // requesters: drop on ready, otherwise (re)issue while work remains
    if (if_req && if_ready) begin
      if_req = 1'b0;
      if_todo--;
    end else if (!if_req && if_todo > 0 && (!rnd || $urandom_range(1) == 1)) begin
      if_req  = 1'b1;
      if_addr = rnd ? $urandom : if_nxt;
    end
    if (d_req && d_ready) begin
      d_req = 1'b0;
      d_todo--;
    end else if (!d_req && d_todo > 0 && (!rnd || $urandom_range(1) == 1)) begin
      d_req   = 1'b1;
      d_we    = rnd ? 1'($urandom_range(1)) : d_nxt_we;
      d_addr  = rnd ? $urandom : d_nxt_addr;
      d_wdata = rnd ? $urandom : d_nxt_wdata;
      d_wstrb = rnd ? 4'($urandom_range(15)) : d_nxt_wstrb;
    end
    if (scr && win) begin
      if (g_port == GNT_IF) if_addr = $urandom;
      else begin
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_wstrb = 4'($urandom_range(15));
        d_we    = 1'($urandom_range(1));
      end
    end
    // memory: ack exactly in the chosen busy cycle; stray acks elsewhere must be ignored
    fire    = win ? (n - g_edge + 1 == dly) : ($urandom_range(3) == 0);
    m_ack   = fire;
    m_rdata = (win && fire) ? e_mem : $urandom;
    // arbitration: a request seen now is granted at the next edge if the bus is free
    if (n + 1 >= free_edge && (if_req || d_req)) begin
      g_port    = (if_req && d_req) ? ~last : (d_req ? GNT_D : GNT_IF);
      last      = g_port;
      g_edge    = n + 1;
      dly       = fix_dly != 0 ? fix_dly : int'($urandom_range(TO + 2, 1));
      len       = dly <= TO ? dly : TO;
      e_err     = dly > TO;
      rsp_cyc   = g_edge + len;
      free_edge = rsp_cyc + 2;
      e_addr    = g_port == GNT_D ? d_addr : if_addr;
      e_we      = g_port == GNT_D && d_we;
      e_wdata   = d_wdata;
      e_wstrb   = e_we ? d_wstrb : 4'h0;
      e_mem     = fix_rd_en ? fix_rd : $urandom;
      e_rsp     = (e_err || e_we) ? 32'h0 : e_mem;
    end
  endtask

  task automatic run_until_idle();
    int k;
    k = 0;
    do begin
      cycle();
      k++;
    end while ((if_todo > 0 || d_todo > 0 || if_req || d_req || n <= rsp_cyc) && k < 5000);
    chk("drain_budget", {31'd0, k >= 5000}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0; m_ack = 1'b0; m_rdata = '0;
    d_nxt_we = 1'b0; d_nxt_addr = '0; d_nxt_wdata = '0; d_nxt_wstrb = '0; if_nxt = '0; fix_rd = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_m_req", {31'd0, m_req}, 32'd0);
    chk("rst_m_we", {31'd0, m_we}, 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_wstrb", {28'd0, m_wstrb}, 32'd0);
    chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
    chk("rst_d_ready", {31'd0, d_ready}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_err", {31'd0, d_err}, 32'd0);
    rst_n = 1'b1;

    // contention straight out of reset: D, IF, D, IF with two pulses each
    if_nxt = 32'h100; d_nxt_addr = 32'h200;
    if_todo = 2; d_todo = 2; glog.delete(); if_cnt = 0; d_cnt = 0;
    run_until_idle();
    order = '{32'h200, 32'h100, 32'h200, 32'h100};
    chk("cont_grants", glog.size(), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("cont_order%0d", i), i < glog.size() ? glog[i] : 32'hx, order[i]);
    chk("cont_if_pulses", if_cnt, 32'd2);
    chk("cont_d_pulses", d_cnt, 32'd2);

    // fetch only, ack in the first busy cycle
    if_nxt = 32'h10; fix_dly = 1; fix_rd_en = 1; fix_rd = 32'h00500093;
    if_cnt = 0; d_cnt = 0; if_todo = 1;
    run_until_idle();
    chk("fetch_if_pulses", if_cnt, 32'd1);
    chk("fetch_d_pulses", d_cnt, 32'd0);

    // store with ack delay 3 while the live inputs are scrambled after grant
    d_nxt_we = 1'b1; d_nxt_addr = 32'h40; d_nxt_wdata = 32'hDEADBEEF; d_nxt_wstrb = 4'hF;
    fix_dly = 3; scr = 1; d_cnt = 0; d_todo = 1;
    run_until_idle();
    chk("store_d_pulses", d_cnt, 32'd1);
    scr = 0;

    // load that never gets an ack
    d_nxt_we = 1'b0; d_nxt_addr = 32'h44; d_nxt_wstrb = 4'h0;
    fix_dly = TO + 5; mreq_cnt = 0; d_todo = 1;
    run_until_idle();
    chk("timeout_mreq_cycles", mreq_cnt, TO);

    // ack arrives in the very cycle the timeout would fire
    fix_dly = TO; fix_rd = 32'h1234; d_todo = 1;
    run_until_idle();

    // reset in the middle of a fetch
    if_nxt = 32'h80; fix_dly = TO + 5; if_todo = 1;
    repeat (3) cycle();
    #2 rst_n = 1'b0;
    #1 chk("async_rst_m_req", {31'd0, m_req}, 32'd0);
    if_req = 1'b0; if_todo = 0; m_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_if_ready", {31'd0, if_ready}, 32'd0);
      chk("rst_hold_m_req", {31'd0, m_req}, 32'd0);
    end
    rst_n = 1'b1;
    model_reset();
    if_nxt = 32'h84; fix_dly = 2; fix_rd = 32'hCAFE0001; if_cnt = 0; if_todo = 1;
    run_until_idle();
    chk("post_rst_if_pulses", if_cnt, 32'd1);

    // random traffic from both ports
    rnd = 1; scr = 1; fix_dly = 0; fix_rd_en = 0;
    if_todo = 30; d_todo = 30;
    run_until_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
